fir_stream_ctrl: RTL and testbench

//  Sequencer in front of the 25-tap transposed-form FIR (19b in, 20b out, free-running, no enable).

---
 rtl/fir_ctrl_pkg.sv | 23 ++
 rtl/fir_stream_ctrl_if.sv | 28 ++
 rtl/fir_in_fifo.sv | 62 ++++++
 rtl/fir_stream_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fir_stream_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR stream sequencer.
//   FIR_XW / FIR_YW : filter input / output sample widths
//   FIR_NTAPS       : filter length (flush length is FIR_NTAPS-1)
//   fir_state_t     : sequencer state
//   fifo_entry_t    : one buffered input sample with its frame-end flag
package fir_ctrl_pkg;

  localparam int unsigned FIR_XW    = 19;
  localparam int unsigned FIR_YW    = 20;
  localparam int unsigned FIR_NTAPS = 25;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } fir_state_t;

  typedef struct packed {
    logic                     last;
    logic signed [FIR_XW-1:0] x;
  } fifo_entry_t;

endpackage

// File: rtl/fir_stream_ctrl_if.sv
// Stream bundle around the FIR sequencer: input sample stream, filter
// input/output pair and the tagged output stream.
//   slave  : sequencer view (takes s_*, fir_y; drives s_ready, fir_x, m_*)
//   master : environment view (source, filter and sink side)
interface fir_stream_ctrl_if;
  import fir_ctrl_pkg::*;

  logic signed [FIR_XW-1:0] s_x;
  logic                     s_valid;
  logic                     s_last;
  logic                     s_ready;
  logic signed [FIR_XW-1:0] fir_x;
  logic signed [FIR_YW-1:0] fir_y;
  logic signed [FIR_YW-1:0] m_y;
  logic                     m_valid;
  logic                     m_last;

  modport slave (
    input  s_x, s_valid, s_last, fir_y,
    output s_ready, fir_x, m_y, m_valid, m_last
  );

  modport master (
    output s_x, s_valid, s_last, fir_y,
    input  s_ready, fir_x, m_y, m_valid, m_last
  );

endinterface

// File: rtl/fir_in_fifo.sv
// Synchronous input FIFO with asynchronous active-high reset.
//   clk, rst     : clock, async reset
//   push, din    : write request and entry
//   pop, dout    : read request and head entry (dout valid when !empty)
//   full, empty  : occupancy flags
//   count        : occupancy, log2(DEPTH)+1 bits
// A pop in the same clock as a push at full frees the slot first, so
// both are honoured.
module fir_in_fifo
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fifo_entry_t              din,
  input  logic                     pop,
  output fifo_entry_t              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_stream_ctrl.sv
// Sequencer in front of a free-running transposed-form FIR. Buffers the
// input stream, feeds the filter one sample per clock per frame, appends
// NTAPS-1 zeros to drain the taps and tags the filter output with
// m_valid/m_last so each frame yields its full convolution.
//   clk, rst  : clock, async active-high reset (shared with the filter)
//   strm      : stream bundle (s_* in, fir_x/fir_y to/from filter, m_* out)
//   busy      : sequencer not idle
//   underrun  : one-clock pulse when the FIFO is empty during RUN
// Optional feature macro FIR_CTRL_STATS_EN adds saturating counters
//   frame_cnt (frames completed) and urun_cnt (underrun clocks).
module fir_stream_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned NTAPS   = FIR_NTAPS,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned PREFILL = 8,
  parameter int unsigned FIR_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_stream_ctrl_if.slave     strm,
  output logic                 busy,
  output logic                 underrun
`ifdef FIR_CTRL_STATS_EN
  ,
  output logic [15:0]          frame_cnt,
  output logic [15:0]          urun_cnt
`endif
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned FCW = 5;

  fir_state_t               state;
  logic [FCW-1:0]           flush_cnt;
  logic signed [FIR_XW-1:0] fir_x_q;
  logic                     tag_v;
  logic                     tag_l;
  logic [FIR_LAT-1:0]       dly_v;
  logic [FIR_LAT-1:0]       dly_l;

  fifo_entry_t              push_entry;
  fifo_entry_t              head;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic [CW-1:0]            count;
  logic [CW-1:0]            last_pend;

  assign push_entry   = '{last: strm.s_last, x: strm.s_x};
  assign push         = strm.s_valid && !full;
  assign pop          = (state == RUN) && !empty;
  assign strm.s_ready = !full;
  assign strm.fir_x   = fir_x_q;
  assign strm.m_y     = strm.fir_y;
  assign strm.m_valid = dly_v[FIR_LAT-1];
  assign strm.m_last  = dly_l[FIR_LAT-1];
  assign busy         = (state != IDLE);

  fir_in_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Number of complete frames (last-tagged entries) waiting in the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pend <= '0;
    end else begin
      case ({push && strm.s_last, pop && head.last})
        2'b10:   last_pend <= last_pend + CW'(1);
        2'b01:   last_pend <= last_pend - CW'(1);
        default: last_pend <= last_pend;
      endcase
    end
  end

  // Sequencer: fir_x and its slot tags are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
      fir_x_q   <= '0;
      tag_v     <= 1'b0;
      tag_l     <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      fir_x_q  <= '0;
      tag_v    <= 1'b0;
      tag_l    <= 1'b0;
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (count >= CW'(PREFILL) || last_pend != '0) state <= RUN;
        end
        RUN: begin
          tag_v <= 1'b1;
          if (!empty) begin
            fir_x_q <= head.x;
            if (head.last) begin
              state     <= FLUSH;
              flush_cnt <= '0;
            end
          end else begin
            // Starved: feed a zero that still counts as frame output.
            underrun <= 1'b1;
          end
        end
        FLUSH: begin
          tag_v     <= 1'b1;
          flush_cnt <= flush_cnt + FCW'(1);
          if (flush_cnt == FCW'(NTAPS - 2)) begin
            tag_l <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tags lag fir_x by FIR_LAT clocks so they line up with fir_y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_v <= '0;
      dly_l <= '0;
    end else begin
      dly_v[0] <= tag_v;
      dly_l[0] <= tag_l;
      for (int unsigned i = 1; i < FIR_LAT; i++) begin
        dly_v[i] <= dly_v[i-1];
        dly_l[i] <= dly_l[i-1];
      end
    end
  end

`ifdef FIR_CTRL_STATS_EN
  // Saturating frame and underrun counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      urun_cnt  <= '0;
    end else begin
      if (dly_l[FIR_LAT-1] && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      if (underrun && urun_cnt != 16'hFFFF)          urun_cnt  <= urun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed bench for fir_stream_ctrl. The filter is replaced by a pure
// FIR_LAT-clock delay of fir_x, so each expected m_y equals the sample fed
// FIR_LAT clocks earlier (zero for idle/flush/underrun slots).
module tb_fir_stream_ctrl;
  import fir_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_stream_ctrl_if bus ();
  fir_stream_ctrl_if bus_f ();

  logic busy, underrun, busy_f, underrun_f;
`ifdef FIR_CTRL_STATS_EN
  logic [15:0] frame_cnt, urun_cnt, frame_cnt_f, urun_cnt_f;
`endif

  fir_stream_ctrl #(.NTAPS(25), .DEPTH(32), .PREFILL(8), .FIR_LAT(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .strm     (bus.slave),
    .busy     (busy),
    .underrun (underrun)
`ifdef FIR_CTRL_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .urun_cnt (urun_cnt)
`endif
  );

  fir_stream_ctrl #(.NTAPS(25), .DEPTH(32), .PREFILL(32), .FIR_LAT(2)) dut_f (
    .clk      (clk),
    .rst      (rst),
    .strm     (bus_f.slave),
    .busy     (busy_f),
    .underrun (underrun_f)
`ifdef FIR_CTRL_STATS_EN
    ,
    .frame_cnt(frame_cnt_f),
    .urun_cnt (urun_cnt_f)
`endif
  );

  // Stand-in filters: two-clock delay of fir_x, sign-extended.
  logic signed [19:0] y1, y2, yf1, yf2;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      y1 <= '0; y2 <= '0; yf1 <= '0; yf2 <= '0;
    end else begin
      y1  <= {bus.fir_x[18], bus.fir_x};
      y2  <= y1;
      yf1 <= {bus_f.fir_x[18], bus_f.fir_x};
      yf2 <= yf1;
    end
  end
  assign bus.fir_y   = y2;
  assign bus_f.fir_y = yf2;

  int errors = 0;
  int checks = 0;

  // Collected observations of the main instance.
  logic signed [19:0] yq[$];
  int lastq[$];
  int frameq[$];
  int n_urun;
  int min_gap;

  task automatic collect(input int cycles);
    int cur = 0;
    int since_last = -1;
    yq.delete(); lastq.delete(); frameq.delete();
    n_urun = 0; min_gap = 9999;
    repeat (cycles) begin
      @(negedge clk);
      if (underrun) n_urun++;
      if (bus.m_valid) begin
        if (since_last >= 0) begin
          if (since_last < min_gap) min_gap = since_last;
          since_last = -1;
        end
        yq.push_back(bus.m_y);
        cur++;
        if (bus.m_last) begin
          lastq.push_back(yq.size() - 1);
          frameq.push_back(cur);
          cur = 0;
          since_last = 0;
        end
      end else if (since_last >= 0) begin
        since_last++;
      end
    end
  endtask

  // Push n samples base..base+n-1 with s_valid held; starts and ends at a negedge.
  task automatic push_frame(input int n, input int base, input bit with_last);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < n && guard < 1000) begin
      bus.s_valid = 1'b1;
      bus.s_x     = 19'(base + i);
      bus.s_last  = with_last && (i == n - 1);
      acc = bus.s_ready;
      @(negedge clk);
      if (acc) i++;
      guard++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    checks++;
    if (i != n) begin
      errors++;
      $display("FAIL push_accept: accepted %0d required %0d", i, n);
    end
  endtask

  task automatic check_seq(input string name, input logic signed [19:0] exp[$]);
    checks++;
    if (yq.size() != exp.size()) begin
      errors++;
      $display("FAIL %s_beats: got %0d required %0d", name, yq.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < yq.size(); i++) begin
      checks++;
      if (yq[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s_y[%0d]: got %0d required %0d", name, i, yq[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b required 1", bus.s_ready); end
    checks++; if (bus.fir_x !== 19'sd0) begin errors++; $display("FAIL reset_fir_x: got %0d required 0", bus.fir_x); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b required 0", bus.m_valid); end
    checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b required 0", bus.m_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b required 0", underrun); end
`ifdef FIR_CTRL_STATS_EN
    checks++; if (frame_cnt !== 16'd0 || urun_cnt !== 16'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d required 0/0", frame_cnt, urun_cnt); end
`endif
  endtask

  task automatic test_impulse;
    logic signed [19:0] exp[$];
    fork
      push_frame(1, 65536, 1'b1);
      collect(60);
    join
    exp.push_back(20'sd65536);
    repeat (24) exp.push_back(20'sd0);
    check_seq("impulse", exp);
    checks++;
    if (lastq.size() != 1 || (lastq.size() == 1 && lastq[0] != 24)) begin
      errors++;
      $display("FAIL impulse_last: got %0d pulses (first at %0d) required 1 at beat 24", lastq.size(), (lastq.size() > 0) ? lastq[0] : -1);
    end
    checks++; if (n_urun != 0) begin errors++; $display("FAIL impulse_underrun: got %0d required 0", n_urun); end
  endtask

  task automatic test_back_to_back;
    logic signed [19:0] exp[$];
    fork
      begin
        push_frame(40, 1000, 1'b1);
        push_frame(10, 2000, 1'b1);
      end
      collect(160);
    join
    for (int i = 0; i < 40; i++) exp.push_back(20'(1000 + i));
    repeat (24) exp.push_back(20'sd0);
    for (int i = 0; i < 10; i++) exp.push_back(20'(2000 + i));
    repeat (24) exp.push_back(20'sd0);
    check_seq("b2b", exp);
    checks++;
    if (frameq.size() != 2 || (frameq.size() == 2 && (frameq[0] != 64 || frameq[1] != 34))) begin
      errors++;
      $display("FAIL b2b_frames: got %0d frames (%0d,%0d) required 2 (64,34)", frameq.size(),
               (frameq.size() > 0) ? frameq[0] : -1, (frameq.size() > 1) ? frameq[1] : -1);
    end
    checks++; if (min_gap < 1 || min_gap == 9999) begin errors++; $display("FAIL b2b_gap: got %0d required >=1", min_gap); end
    checks++; if (n_urun != 0) begin errors++; $display("FAIL b2b_underrun: got %0d required 0", n_urun); end
  endtask

  task automatic test_underrun;
    logic signed [19:0] exp[$];
    fork
      begin
        int g = 0;
        push_frame(8, 100, 1'b0);
        while (!underrun && g < 200) begin @(negedge clk); g++; end
        checks++; if (!underrun) begin errors++; $display("FAIL urun_start: got 0 required 1 within 200 clocks"); end
        // Resume so the first new sample lands on the fifth starved clock.
        repeat (3) @(negedge clk);
        push_frame(4, 200, 1'b1);
      end
      collect(100);
    join
    for (int i = 0; i < 8; i++) exp.push_back(20'(100 + i));
    repeat (5) exp.push_back(20'sd0);
    for (int i = 0; i < 4; i++) exp.push_back(20'(200 + i));
    repeat (24) exp.push_back(20'sd0);
    check_seq("urun", exp);
    checks++; if (n_urun != 5) begin errors++; $display("FAIL urun_pulses: got %0d required 5", n_urun); end
    checks++;
    if (lastq.size() != 1 || (lastq.size() == 1 && lastq[0] != 40)) begin
      errors++;
      $display("FAIL urun_last: got %0d pulses required 1 at beat 40", lastq.size());
    end
  endtask

  task automatic test_full_fifo;
    logic signed [19:0] q[$];
    int acc_cnt = 0;
    int first_block = -1;
    int maxc = 0;
    fork
      begin
        int guard = 0;
        bit acc;
        while (acc_cnt < 40 && guard < 1000) begin
          bus_f.s_valid = 1'b1;
          bus_f.s_x     = 19'(500 + acc_cnt);
          bus_f.s_last  = 1'b0;
          acc = bus_f.s_ready;
          if (!acc && first_block < 0) first_block = acc_cnt;
          @(negedge clk);
          if (acc) acc_cnt++;
          guard++;
        end
        bus_f.s_valid = 1'b0;
      end
      repeat (120) begin
        @(negedge clk);
        if (bus_f.m_valid) q.push_back(bus_f.m_y);
        if (int'(dut_f.u_fifo.count) > maxc) maxc = int'(dut_f.u_fifo.count);
      end
    join
    checks++; if (acc_cnt != 40) begin errors++; $display("FAIL full_accepts: got %0d required 40", acc_cnt); end
    checks++; if (first_block != 32) begin errors++; $display("FAIL full_ready_drop: got %0d accepts required 32", first_block); end
    checks++; if (maxc != 32) begin errors++; $display("FAIL full_max_count: got %0d required 32", maxc); end
    checks++; if (q.size() < 40) begin errors++; $display("FAIL full_beats: got %0d required >=40", q.size()); end
    for (int i = 0; i < 40 && i < q.size(); i++) begin
      checks++;
      if (q[i] !== 20'(500 + i)) begin errors++; $display("FAIL full_y[%0d]: got %0d required %0d", i, q[i], 500 + i); end
    end
    checks++; if (busy_f !== 1'b1 || underrun_f !== 1'b1) begin errors++; $display("FAIL full_starved: got busy=%b underrun=%b required 1/1", busy_f, underrun_f); end
  endtask

  task automatic test_reset_mid_flush;
    int g = 0;
    fork
      push_frame(1, 65536, 1'b1);
      while (!(dut.state == FLUSH && dut.flush_cnt == 5'd10) && g < 100) begin @(negedge clk); g++; end
    join
    checks++; if (g >= 100) begin errors++; $display("FAIL rmf_reach_flush: got timeout required flush clock 10"); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rmf_m_valid: got %b required 0", bus.m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmf_busy: got %b required 0", busy); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rmf_s_ready: got %b required 1", bus.s_ready); end
    checks++; if (dut.u_fifo.count !== 6'd0) begin errors++; $display("FAIL rmf_count: got %0d required 0", dut.u_fifo.count); end
    rst = 1'b0;
    @(negedge clk);
    test_impulse();
  endtask

`ifdef FIR_CTRL_STATS_EN
  task automatic test_stats;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_back_to_back();
    test_underrun();
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL stats_frames: got %0d required 3", frame_cnt); end
    checks++; if (urun_cnt !== 16'd5) begin errors++; $display("FAIL stats_urun: got %0d required 5", urun_cnt); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (frame_cnt !== 16'd0 || urun_cnt !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d/%0d required 0/0", frame_cnt, urun_cnt); end
  endtask
`endif

  initial begin
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_x = '0;
    bus_f.s_valid = 1'b0; bus_f.s_last = 1'b0; bus_f.s_x = '0;
    test_reset();
    test_impulse();
    test_back_to_back();
    test_underrun();
    test_full_fifo();
    test_reset_mid_flush();
`ifdef FIR_CTRL_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
